comb1_sched: RTL and testbench
==============================

# comb1_sched

Sequencing controller for the comb1 operator datapath. Accepts one operand set (A, B, C, D) per transaction via valid/ready, holds it on the datapath inputs, waits a configurable settle time and snapshots all nine operator result buses. It then streams the nine results out one per handshake, tagged with a category index. It sits between an operand producer and a narrow 4-bit result consumer, so the wide datapath output never needs to be routed in parallel.

## Interface
- `WIDTH`, 4, operand and result width.
- `SETTLE_CYCLES`, 1, cycles (≥1) operands are held before snapshot; legal range 1–15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand set valid.
- `in_ready` out 1: controller can accept an operand set.
- `in_a`, `in_b`, `in_c`, `in_d` in WIDTH each: operands.
- `dp_a`, `dp_b`, `dp_c`, `dp_d` out WIDTH each: registered operands driven to the datapath.
- `dp_res` in 9×WIDTH: datapath results, concatenated, index 0 in LSBs. Order: 0 Arithmetic, 1 Shift, 2 Relational, 3 Equality, 4 Bitwise, 5 Reduction, 6 Logical, 7 Concatenation, 8 Conditional.
- `out_valid` out 1: result word valid.
- `out_ready` in 1: consumer accepts the word.
- `out_data` out WIDTH: result word.
- `out_idx` out 4: category index of `out_data`.
- `out_last` out 1: final word of the transaction.
- `done` out 1: one-cycle pulse after the last word is accepted.
- `busy` out 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, SETTLE, EMIT.
- IDLE:
  - `in_ready`=1.
  - When `in_valid`&&`in_ready`, capture operands into `dp_*`, load the settle counter with SETTLE_CYCLES−1, and go to SETTLE.
- SETTLE:
  - Decrement the counter each cycle.
  - When the counter is 0, capture `dp_res` into a 9-word snapshot, set the index to the first enabled category, and go to EMIT.
- EMIT:
  - `out_valid`=1; `out_data`=snapshot[idx]; `out_idx`=idx.
  - `out_last`=1 when idx is the last enabled category.
  - On `out_valid`&&`out_ready`, advance idx to the next enabled category.
  - If the accepted word had `out_last`=1, go to IDLE and pulse `done`.
- Backpressure: while `out_valid`&&!`out_ready`, `out_data`, `out_idx` and `out_last` hold stable.
- `dp_*` hold the captured operands until the next accept. Only operands and snapshot are stored; no datapath arithmetic is done here.
- `in_ready` is low in SETTLE and EMIT. Operand writes during a transaction are impossible.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - `dp_*`, snapshot, idx, counter, `out_data`, `out_idx` → 0.
  - `out_valid`, `out_last`, `done`, `busy` → 0.
  - `in_ready` → 1 after release.
  - A partially emitted transaction is discarded.

## Timing
- Accept at edge T. Snapshot at edge T+SETTLE_CYCLES. First `out_valid` is high in the cycle after that edge.
- With `out_ready` tied high, words 0..8 occupy 9 consecutive cycles. `done` is high the cycle after word 8.
- Full transaction with no backpressure: 1 + SETTLE_CYCLES + 9 cycles from accept to `in_ready` high again.
- `in_ready` goes high in the same cycle `done` is high. No overlap of consecutive transactions.
- `out_idx` always increases within a transaction. Word 0 is never emitted after word 8.

## Configuration
- `COMB1_SCHED_MASK_EN` defined:
  - Adds input `in_mask` (9 bits), captured with the operands. Bit i=0 skips category i.
  - `out_last` marks the highest enabled index.
  - If `in_mask`==0: no words are emitted, and SETTLE goes directly to IDLE with a `done` pulse.
- Not defined:
  - Port is absent and all nine categories are always emitted.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-cycle → all outputs at the reset values above immediately. After release, `in_ready`=1 and `busy`=0.
- **Basic stream:**
  - Stimulus: SETTLE_CYCLES=1; A=4'b1100, B=4'b0110, C=4'b0010, D=4'b1100; bench drives `dp_res` word i = i+1; `out_ready`=1.
  - Response: `dp_*` match the operands the cycle after accept. `out_data` is 1..9 with `out_idx` 0..8 on consecutive cycles. `out_last` only on index 8. `done` one cycle later.
- **Backpressure:**
  - Stimulus: drop `out_ready` for 3 cycles at idx 4.
  - Response: `out_data`=5 and `out_idx`=4 stay stable. The stream resumes at idx 5 with no loss or duplication.
- **Settle/snapshot:**
  - Stimulus: SETTLE_CYCLES=3; change `dp_res` after the snapshot edge.
  - Response: first `out_valid` 4 cycles after accept. Emitted words reflect only the pre-snapshot values.
- **Reset mid-EMIT:**
  - Stimulus: assert `rst_n` at idx 2, then send a new operand set.
  - Response: the new transaction starts at idx 0. No stale words appear.
- **Mask (`COMB1_SCHED_MASK_EN`):**
  - `in_mask`=9'b100010001 → only idx 0, 4, 8 are emitted; `out_last` on idx 8.
  - `in_mask`=0 → no `out_valid`; `done` 2 cycles after accept.

Source files
------------

// File: rtl/comb1_sched.sv
`default_nettype none
// comb1_sched: holds one operand set on the comb1 datapath, snapshots the nine
// result buses after a settle time and streams them out one word per handshake.
// Optional skip mask: define COMB1_SCHED_MASK_EN to add i_in_mask.
module comb1_sched #(
   parameter int WIDTH         = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_in_valid,
   output logic               o_in_ready,
   input  logic [WIDTH-1:0]   i_in_a,
   input  logic [WIDTH-1:0]   i_in_b,
   input  logic [WIDTH-1:0]   i_in_c,
   input  logic [WIDTH-1:0]   i_in_d,
`ifdef COMB1_SCHED_MASK_EN
   input  logic [8:0]         i_in_mask,
`endif
   output logic [WIDTH-1:0]   o_dp_a,
   output logic [WIDTH-1:0]   o_dp_b,
   output logic [WIDTH-1:0]   o_dp_c,
   output logic [WIDTH-1:0]   o_dp_d,
   input  logic [9*WIDTH-1:0] i_dp_res,
   output logic               o_out_valid,
   input  logic               i_out_ready,
   output logic [WIDTH-1:0]   o_out_data,
   output logic [3:0]         o_out_idx,
   output logic               o_out_last,
   output logic               o_done,
   output logic               o_busy
);
   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_SETTLE   = 2'd1;
   localparam logic [1:0] S_EMIT     = 2'd2;
   localparam int         C_NCAT     = 9;
   localparam logic [3:0] C_CNT_LOAD = 4'(SETTLE_CYCLES - 1);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [3:0]       r_cnt;
   logic [3:0]       r_idx;
   logic             r_done;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_c;
   logic [WIDTH-1:0] r_d;
   logic [WIDTH-1:0] r_snap [C_NCAT];
   logic [8:0]       w_mask;
   logic             w_accept;
   logic             w_is_last;
   logic [3:0]       w_first_idx;
   logic [3:0]       w_next_idx;
   logic [3:0]       w_last_idx;
   logic [WIDTH-1:0] w_sel_data;

`ifdef COMB1_SCHED_MASK_EN
   logic [8:0] r_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_mask <= '0;
      else if (w_accept)
         r_mask <= i_in_mask;
   end

   assign w_mask = r_mask;
`else
   assign w_mask = '1;
`endif

   assign w_accept  = (r_state == S_IDLE) && i_in_valid;
   assign w_is_last = (r_idx == w_last_idx);

   // Lowest enabled category, next enabled above r_idx, and highest enabled.
   always_comb begin
      w_first_idx = 4'd0;
      w_next_idx  = 4'd0;
      w_last_idx  = 4'd0;
      for (int i = C_NCAT - 1; i >= 0; i--) begin
         if (w_mask[i])
            w_first_idx = 4'(i);
         if (w_mask[i] && (4'(i) > r_idx))
            w_next_idx = 4'(i);
      end
      for (int i = 0; i < C_NCAT; i++) begin
         if (w_mask[i])
            w_last_idx = 4'(i);
      end
   end

   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < C_NCAT; i++) begin
         if (r_idx == 4'(i))
            w_sel_data = r_snap[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_state_nxt = S_SETTLE;
         S_SETTLE: if (r_cnt == 4'd0) w_state_nxt = (w_mask == 9'd0) ? S_IDLE : S_EMIT;
         S_EMIT:   if (i_out_ready && w_is_last) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_in_ready  = (r_state == S_IDLE);
      o_busy      = (r_state != S_IDLE);
      o_out_valid = 1'b0;
      o_out_data  = '0;
      o_out_idx   = 4'd0;
      o_out_last  = 1'b0;
      if (r_state == S_EMIT) begin
         o_out_valid = 1'b1;
         o_out_data  = w_sel_data;
         o_out_idx   = r_idx;
         o_out_last  = w_is_last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_c    <= '0;
         r_d    <= '0;
         r_cnt  <= 4'd0;
         r_idx  <= 4'd0;
         r_done <= 1'b0;
         for (int i = 0; i < C_NCAT; i++)
            r_snap[i] <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_a   <= i_in_a;
                  r_b   <= i_in_b;
                  r_c   <= i_in_c;
                  r_d   <= i_in_d;
                  r_cnt <= C_CNT_LOAD;
               end
            end
            S_SETTLE: begin
               if (r_cnt == 4'd0) begin
                  for (int i = 0; i < C_NCAT; i++)
                     r_snap[i] <= i_dp_res[i*WIDTH +: WIDTH];
                  r_idx  <= w_first_idx;
                  r_done <= (w_mask == 9'd0);
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_EMIT: begin
               if (i_out_ready) begin
                  r_idx  <= w_next_idx;
                  r_done <= w_is_last;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_dp_a = r_a;
   assign o_dp_b = r_b;
   assign o_dp_c = r_c;
   assign o_dp_d = r_d;
   assign o_done = r_done;
endmodule
`default_nettype wire

// File: tb/tb_comb1_sched.sv
`default_nettype none
// tb_comb1_sched: two DUT lanes (settle 1 and settle 3) checked every cycle
// against a transaction-level model, plus directed literal checks.
module tb_comb1_sched;
   localparam int NL = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        vld [NL], ir [NL], ov [NL], ordy [NL], ol [NL], dn [NL], bz [NL];
   logic [3:0]  ia [NL], ib [NL], ic [NL], idd [NL];
   logic [3:0]  da [NL], db [NL], dc [NL], dd [NL], od [NL], oi [NL];
   logic [35:0] dpr [NL];
`ifdef COMB1_SCHED_MASK_EN
   logic [8:0]  msk [NL];
`endif

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   comb1_sched #(.WIDTH(4), .SETTLE_CYCLES(1)) u_s1 (
      .clk(clk), .rst_n(rst_n),
      .i_in_valid(vld[0]), .o_in_ready(ir[0]),
      .i_in_a(ia[0]), .i_in_b(ib[0]), .i_in_c(ic[0]), .i_in_d(idd[0]),
`ifdef COMB1_SCHED_MASK_EN
      .i_in_mask(msk[0]),
`endif
      .o_dp_a(da[0]), .o_dp_b(db[0]), .o_dp_c(dc[0]), .o_dp_d(dd[0]),
      .i_dp_res(dpr[0]),
      .o_out_valid(ov[0]), .i_out_ready(ordy[0]), .o_out_data(od[0]),
      .o_out_idx(oi[0]), .o_out_last(ol[0]), .o_done(dn[0]), .o_busy(bz[0])
   );

   comb1_sched #(.WIDTH(4), .SETTLE_CYCLES(3)) u_s3 (
      .clk(clk), .rst_n(rst_n),
      .i_in_valid(vld[1]), .o_in_ready(ir[1]),
      .i_in_a(ia[1]), .i_in_b(ib[1]), .i_in_c(ic[1]), .i_in_d(idd[1]),
`ifdef COMB1_SCHED_MASK_EN
      .i_in_mask(msk[1]),
`endif
      .o_dp_a(da[1]), .o_dp_b(db[1]), .o_dp_c(dc[1]), .o_dp_d(dd[1]),
      .i_dp_res(dpr[1]),
      .o_out_valid(ov[1]), .i_out_ready(ordy[1]), .o_out_data(od[1]),
      .o_out_idx(oi[1]), .o_out_last(ol[1]), .o_done(dn[1]), .o_busy(bz[1])
   );

   function automatic int settle_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string nm, input int k, input logic [35:0] act, input logic [35:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s lane%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
      end
   endtask

   // Model: a transaction is idle (0), waiting (1) or a list of pending words (2).
   int         m_ph [NL], m_wait [NL], m_n [NL], m_p [NL];
   bit         m_done [NL];
   logic [3:0] m_a [NL], m_b [NL], m_c [NL], m_d [NL];
   logic [8:0] m_msk [NL];
   logic [3:0] m_li [NL][9];
   logic [3:0] m_ld [NL][9];

   task automatic model_step(input int k);
      m_done[k] = 1'b0;
      if (m_ph[k] == 0) begin
         if (vld[k]) begin
            m_a[k] = ia[k]; m_b[k] = ib[k]; m_c[k] = ic[k]; m_d[k] = idd[k];
`ifdef COMB1_SCHED_MASK_EN
            m_msk[k] = msk[k];
`else
            m_msk[k] = 9'h1FF;
`endif
            m_wait[k] = settle_of(k);
            m_ph[k]   = 1;
         end
      end else if (m_ph[k] == 1) begin
         m_wait[k]--;
         if (m_wait[k] == 0) begin
            m_n[k] = 0;
            m_p[k] = 0;
            for (int i = 0; i < 9; i++) begin
               if (m_msk[k][i]) begin
                  m_li[k][m_n[k]] = 4'(i);
                  m_ld[k][m_n[k]] = dpr[k][i*4 +: 4];
                  m_n[k]++;
               end
            end
            if (m_n[k] == 0) begin
               m_done[k] = 1'b1;
               m_ph[k]   = 0;
            end else begin
               m_ph[k] = 2;
            end
         end
      end else if (ordy[k]) begin
         m_p[k]++;
         if (m_p[k] == m_n[k]) begin
            m_done[k] = 1'b1;
            m_ph[k]   = 0;
         end
      end
   endtask

   initial begin
      for (int k = 0; k < NL; k++) begin
         m_ph[k] = 0; m_p[k] = 0; m_n[k] = 0; m_done[k] = 1'b0;
      end
      forever begin
         @(posedge clk or negedge rst_n);
         for (int k = 0; k < NL; k++) begin
            if (!rst_n) begin
               m_ph[k] = 0; m_p[k] = 0; m_n[k] = 0; m_done[k] = 1'b0;
               m_a[k] = '0; m_b[k] = '0; m_c[k] = '0; m_d[k] = '0;
            end else begin
               model_step(k);
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int k = 0; k < NL; k++) begin
               chk("in_ready", k, ir[k], m_ph[k] == 0);
               chk("busy", k, bz[k], m_ph[k] != 0);
               chk("out_valid", k, ov[k], m_ph[k] == 2);
               chk("done", k, dn[k], m_done[k]);
               chk("dp_abcd", k, {da[k], db[k], dc[k], dd[k]}, {m_a[k], m_b[k], m_c[k], m_d[k]});
               if (m_ph[k] == 2) begin
                  chk("out_data", k, od[k], m_ld[k][m_p[k]]);
                  chk("out_idx", k, oi[k], m_li[k][m_p[k]]);
                  chk("out_last", k, ol[k], m_p[k] == m_n[k] - 1);
               end
            end
         end
      end
   end

   task automatic wait_idle(input int k);
      int n;
      vld[k]  = 1'b0;
      ordy[k] = 1'b1;
      n = 0;
      while (!ir[k] && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", k, ir[k], 1'b1);
   endtask

   task automatic basic(input int k, input bit bp);
      logic [35:0] pat;
      pat = 36'h987654321;
      wait_idle(k);
      @(posedge clk); #1;
      ia[k] = 4'b1100; ib[k] = 4'b0110; ic[k] = 4'b0010; idd[k] = 4'b1100;
`ifdef COMB1_SCHED_MASK_EN
      msk[k] = 9'h1FF;
`endif
      dpr[k] = pat; ordy[k] = 1'b1; vld[k] = 1'b1;
      @(posedge clk); #1;
      vld[k] = 1'b0;
      chk("dp_after_accept", k, {da[k], db[k], dc[k], dd[k]}, 16'hC62C);
      for (int s = 0; s < settle_of(k); s++) begin
         @(negedge clk);
         chk("settle_valid", k, ov[k], 1'b0);
         chk("settle_busy", k, bz[k], 1'b1);
      end
      for (int i = 0; i < 9; i++) begin
         if (i == 0) begin
            @(posedge clk); #1;
            dpr[k] = ~pat;
         end
         @(negedge clk);
         chk("word_valid", k, ov[k], 1'b1);
         chk("word_data", k, od[k], 36'(i + 1));
         chk("word_idx", k, oi[k], 36'(i));
         chk("word_last", k, ol[k], i == 8);
         if (bp && i == 4) begin
            ordy[k] = 1'b0;
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               chk("bp_data", k, od[k], 36'd5);
               chk("bp_idx", k, oi[k], 36'd4);
            end
            ordy[k] = 1'b1;
         end
      end
      @(negedge clk);
      chk("end_done", k, dn[k], 1'b1);
      chk("end_ready", k, ir[k], 1'b1);
      chk("end_valid", k, ov[k], 1'b0);
   endtask

   task automatic random_phase(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         for (int k = 0; k < NL; k++) begin
            vld[k]  = ($urandom_range(0, 2) == 0);
            ia[k]   = 4'($urandom); ib[k] = 4'($urandom);
            ic[k]   = 4'($urandom); idd[k] = 4'($urandom);
            dpr[k]  = {4'($urandom), 32'($urandom)};
            ordy[k] = ($urandom_range(0, 3) != 0);
`ifdef COMB1_SCHED_MASK_EN
            case ($urandom_range(0, 5))
               0:       msk[k] = 9'h000;
               1:       msk[k] = 9'h1FF;
               default: msk[k] = 9'($urandom);
            endcase
`endif
         end
      end
      @(posedge clk); #1;
      for (int k = 0; k < NL; k++) begin
         vld[k]  = 1'b0;
         ordy[k] = 1'b1;
      end
   endtask

   task automatic mid_reset_test();
      int n;
      logic [35:0] q;
      wait_idle(0);
      @(posedge clk); #1;
`ifdef COMB1_SCHED_MASK_EN
      msk[0] = 9'h1FF;
`endif
      dpr[0] = 36'h0FEDCBA98; vld[0] = 1'b1;
      @(posedge clk); #1;
      vld[0] = 1'b0;
      n = 0;
      while (!(ov[0] && oi[0] == 4'd2) && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("reach_idx2", 0, oi[0], 36'd2);
      #1 rst_n = 1'b0;
      #1;
      for (int k = 0; k < NL; k++) begin
         chk("rst_valid", k, ov[k], 1'b0);
         chk("rst_last", k, ol[k], 1'b0);
         chk("rst_done", k, dn[k], 1'b0);
         chk("rst_busy", k, bz[k], 1'b0);
         chk("rst_data", k, od[k], 36'd0);
         chk("rst_idx", k, oi[k], 36'd0);
         chk("rst_dp", k, {da[k], db[k], dc[k], dd[k]}, 36'd0);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NL; k++) begin
         chk("rel_ready", k, ir[k], 1'b1);
         chk("rel_busy", k, bz[k], 1'b0);
      end
      q = 36'h13579BDF2;
      @(posedge clk); #1;
      dpr[0] = q; vld[0] = 1'b1;
      @(posedge clk); #1;
      vld[0] = 1'b0;
      n = 0;
      while (!ov[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("restart_idx", 0, oi[0], 36'd0);
      chk("restart_data", 0, od[0], 36'h2);
   endtask

`ifdef COMB1_SCHED_MASK_EN
   task automatic mask_test();
      int e [3];
      e = '{0, 4, 8};
      wait_idle(0);
      @(posedge clk); #1;
      msk[0] = 9'b100010001; dpr[0] = 36'h987654321; vld[0] = 1'b1;
      @(posedge clk); #1;
      vld[0] = 1'b0;
      @(negedge clk);
      chk("mask_settle", 0, ov[0], 1'b0);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("mask_valid", 0, ov[0], 1'b1);
         chk("mask_idx", 0, oi[0], 36'(e[j]));
         chk("mask_data", 0, od[0], 36'(e[j] + 1));
         chk("mask_last", 0, ol[0], j == 2);
      end
      @(negedge clk);
      chk("mask_done", 0, dn[0], 1'b1);
      @(posedge clk); #1;
      msk[0] = 9'h000; vld[0] = 1'b1;
      @(posedge clk); #1;
      vld[0] = 1'b0;
      @(negedge clk);
      chk("mask0_valid_a", 0, ov[0], 1'b0);
      chk("mask0_done_a", 0, dn[0], 1'b0);
      @(negedge clk);
      chk("mask0_valid_b", 0, ov[0], 1'b0);
      chk("mask0_done_b", 0, dn[0], 1'b1);
      chk("mask0_ready", 0, ir[0], 1'b1);
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < NL; k++) begin
         vld[k] = 1'b0; ordy[k] = 1'b1; dpr[k] = '0;
         ia[k] = '0; ib[k] = '0; ic[k] = '0; idd[k] = '0;
`ifdef COMB1_SCHED_MASK_EN
         msk[k] = 9'h1FF;
`endif
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NL; k++) begin
         chk("init_ready", k, ir[k], 1'b1);
         chk("init_busy", k, bz[k], 1'b0);
         chk("init_valid", k, ov[k], 1'b0);
         chk("init_dp", k, {da[k], db[k], dc[k], dd[k]}, 36'd0);
      end
      chk_en = 1'b1;
      basic(0, 1'b0);
      basic(0, 1'b1);
      basic(1, 1'b0);
      basic(1, 1'b1);
      random_phase(1500);
      mid_reset_test();
`ifdef COMB1_SCHED_MASK_EN
      mask_test();
`endif
      random_phase(500);
      repeat (20) @(posedge clk);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish at %0t", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
